// File: rtl/mycpu_pkg.sv
// Shared pipeline definitions for the LoongArch core (IF/ID stages).
// FS_ADEF_EN widens the IF->ID bus by one bit to carry the fetch-address-error flag.
package mycpu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;
    localparam int          BR_BUS_WD        = 33;
    localparam logic [31:0] INST_NOP         = 32'h0340_0000;

`ifdef FS_ADEF_EN
    localparam int FS_TO_DS_BUS_WD = 65;
`else
    localparam int FS_TO_DS_BUS_WD = 64;
`endif

    function automatic logic pc_misaligned(input logic [31:0] pc);
        return (pc[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// IF-stage boundary: IF->ID handshake, ID->IF redirect, and instruction SRAM port.
// Bus width follows FS_TO_DS_BUS_WD, which depends on FS_ADEF_EN.
interface if_stage_if;
    import mycpu_pkg::*;

    logic                       ds_allowin;
    logic                       br_taken;
    logic [31:0]                br_target;
    logic                       fs_to_ds_valid;
    logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus;
    logic                       inst_sram_en;
    logic [3:0]                 inst_sram_we;
    logic [31:0]                inst_sram_addr;
    logic [31:0]                inst_sram_wdata;
    logic [31:0]                inst_sram_rdata;

    modport master (
        input  ds_allowin, br_taken, br_target, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_taken, br_target, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus,
               inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

endinterface

// File: rtl/if_stage_inst_buf.sv
// Holds the fetched instruction while ID stalls, so the SRAM output may change
// freely once its read enable drops.
module fs_inst_buf
    import mycpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_valid,
    input  logic        fs_allowin,
    input  logic        sram_en,
    input  logic [31:0] sram_rdata,
    output logic [31:0] fs_inst
);

    logic        buf_valid_r;
    logic        rdata_fresh_r;
    logic [31:0] inst_buf_r;

    // Track whether SRAM output belongs to the IF slot; capture it on the first stalled cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_r   <= 1'b0;
            rdata_fresh_r <= 1'b0;
            inst_buf_r    <= INST_NOP;
        end else if (fs_allowin) begin
            rdata_fresh_r <= sram_en;
            buf_valid_r   <= 1'b0;
        end else begin
            rdata_fresh_r <= 1'b0;
            if (fs_valid && rdata_fresh_r) begin
                inst_buf_r  <= sram_rdata;
                buf_valid_r <= 1'b1;
            end
        end
    end

    assign fs_inst = buf_valid_r ? inst_buf_r : sram_rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, next-PC generation, SRAM read, IF->ID handshake.
// With FS_ADEF_EN, misaligned fetch addresses are not read and are flagged on bus bit 64.
module if_stage
    import mycpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic         clk,
    input  logic         reset,
    if_stage_if.master   fs_if
);

    logic                 fs_valid_r;
    logic [31:0]          fs_pc_r;
    logic                 to_fs_valid_s;
    logic                 fs_ready_go_s;
    logic                 fs_allowin_s;
    logic [31:0]          seq_pc_s;
    logic [31:0]          nextpc_s;
    logic                 sram_en_s;
    logic [31:0]          fs_inst_s;
    logic [BR_BUS_WD-1:0] br_bus_s;
    logic                 br_taken_s;
    logic [31:0]          br_target_s;

    assign br_bus_s                  = {fs_if.br_taken, fs_if.br_target};
    assign {br_taken_s, br_target_s} = br_bus_s;

    assign to_fs_valid_s = ~reset;
    assign seq_pc_s      = fs_pc_r + 32'd4;
    assign nextpc_s      = br_taken_s ? br_target_s : seq_pc_s;

    assign fs_ready_go_s = 1'b1;
    // A taken branch kills the IF instruction, so the slot is free regardless of ID
    assign fs_allowin_s  = ~fs_valid_r | fs_if.ds_allowin | br_taken_s;

`ifdef FS_ADEF_EN
    logic adef_s;
    logic adef_r;

    assign adef_s    = pc_misaligned(nextpc_s);
    assign sram_en_s = to_fs_valid_s & fs_allowin_s & ~adef_s;
`else
    assign sram_en_s = to_fs_valid_s & fs_allowin_s;
`endif

    // IF slot state: loads the next PC whenever the slot can be refilled
    always_ff @(posedge clk) begin
        if (reset) begin
            fs_valid_r <= 1'b0;
            fs_pc_r    <= RESET_PC - 32'd4;
`ifdef FS_ADEF_EN
            adef_r     <= 1'b0;
`endif
        end else if (fs_allowin_s) begin
            fs_valid_r <= to_fs_valid_s;
            fs_pc_r    <= nextpc_s;
`ifdef FS_ADEF_EN
            adef_r     <= adef_s;
`endif
        end
    end

    fs_inst_buf u_inst_buf (
        .clk        (clk),
        .reset      (reset),
        .fs_valid   (fs_valid_r),
        .fs_allowin (fs_allowin_s),
        .sram_en    (sram_en_s),
        .sram_rdata (fs_if.inst_sram_rdata),
        .fs_inst    (fs_inst_s)
    );

    assign fs_if.fs_to_ds_valid  = fs_valid_r & fs_ready_go_s & ~br_taken_s;
`ifdef FS_ADEF_EN
    assign fs_if.fs_to_ds_bus    = {adef_r, (adef_r ? 32'h0000_0000 : fs_inst_s), fs_pc_r};
`else
    assign fs_if.fs_to_ds_bus    = {fs_inst_s, fs_pc_r};
`endif

    assign fs_if.inst_sram_en    = sram_en_s;
    assign fs_if.inst_sram_we    = 4'h0;
    assign fs_if.inst_sram_addr  = nextpc_s;
    assign fs_if.inst_sram_wdata = 32'h0000_0000;

endmodule
